// File: rtl/clk_div_checker_pkg.sv
// Shared definitions for the divided-clock checker: channel count, channel FSM states
// and the expected-period function.
package clk_div_checker_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_WAIT_EDGE,
    CH_MEASURE,
    CH_LOCKED
  } chan_state_t;

  // Channel k nominally divides clk by 2^(k+1).
  function automatic int unsigned exp_period(input int unsigned ch);
    return 32'd2 << ch;
  endfunction

endpackage

// File: rtl/clk_div_chan_checker.sv
// One checker channel: synchronizer, rising-edge detect, period counter and lock FSM.
// Optional high-time check when CLK_DIV_CHECKER_DUTY_EN is defined.
module clk_div_chan_checker
  import clk_div_checker_pkg::*;
#(
  parameter int CH          = 0,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             start,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] period
);

  localparam int unsigned      EXP      = exp_period(CH);
  localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXP);
  localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(2 * EXP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   level;
  logic                   rise;
  chan_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             good;
  logic [4:0]             good_next;
  logic                   bad;
  logic                   timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], div};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level     = sync[SYNC_STAGES-1];
  assign rise      = level & ~prev;
  assign good_next = {1'b0, good} + 5'd1;
  assign timeout   = (cnt == TMO_C) && !rise;

`ifdef CLK_DIV_CHECKER_DUTY_EN
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(EXP / 2);

  // hi counts high cycles of the current period, including the edge cycle itself.
  logic [CNT_W-1:0] hi;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      hi <= '0;
    end else if (rise) begin
      hi <= CNT_W'(1);
    end else if (level && hi != CNT_MAX) begin
      hi <= hi + 1'b1;
    end
  end

  assign bad = (cnt != EXP_C) || (hi != HALF_C);
`else
  assign bad = (cnt != EXP_C);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CH_IDLE;
      cnt    <= '0;
      good   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
      period <= '0;
    end else if (start) begin
      state  <= CH_WAIT_EDGE;
      cnt    <= '0;
      good   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
      period <= '0;
    end else begin
      case (state)
        CH_IDLE: begin
          state <= CH_IDLE;
        end
        CH_WAIT_EDGE: begin
          if (rise) begin
            state <= CH_MEASURE;
            cnt   <= CNT_W'(1);
          end
        end
        CH_MEASURE, CH_LOCKED: begin
          if (rise) begin
            cnt    <= CNT_W'(1);
            period <= cnt;
            if (bad) begin
              good <= '0;
              if (state == CH_LOCKED) begin
                err    <= 1'b1;
                locked <= 1'b0;
                state  <= CH_MEASURE;
              end
            end else if (state == CH_MEASURE) begin
              good <= good_next[3:0];
              if (good_next >= LOCK_TGT) begin
                state  <= CH_LOCKED;
                locked <= 1'b1;
              end
            end
          end else if (timeout) begin
            // A missing edge is judged once, then the channel waits for a fresh edge.
            cnt   <= '0;
            good  <= '0;
            state <= CH_WAIT_EDGE;
            if (state == CH_LOCKED) begin
              err    <= 1'b1;
              locked <= 1'b0;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= CH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_checker.sv
// Four-channel divided-clock checker with a registered period readback mux.
// Define CLK_DIV_CHECKER_DUTY_EN to also check the high time of every period.
module clk_div_checker
  import clk_div_checker_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       div_in,
  input  logic             start,
  input  logic [1:0]       meas_sel,
  output logic [3:0]       locked,
  output logic [3:0]       err,
  output logic             err_any,
  output logic [CNT_W-1:0] meas_period
);

  logic [CNT_W-1:0] chan_period [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan_checker #(
      .CH          (g),
      .SYNC_STAGES (SYNC_STAGES),
      .LOCK_COUNT  (LOCK_COUNT),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .div    (div_in[g]),
      .start  (start),
      .locked (locked[g]),
      .err    (err[g]),
      .period (chan_period[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_any     <= 1'b0;
      meas_period <= '0;
    end else begin
      err_any     <= |err;
      meas_period <= chan_period[meas_sel];
    end
  end

endmodule

// File: tb/tb_clk_div_checker.sv
// Self-checking bench for clk_div_checker: directed scenarios plus random disturbances,
// compared every cycle against an edge-timestamp reference model.
module tb_clk_div_checker;

  localparam int SYNC_STAGES = 2;
  localparam int LOCK_COUNT  = 4;
  localparam int CNT_W       = 6;
  localparam int NCH         = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       div_in;
  logic [1:0]       meas_sel;
  logic [3:0]       locked;
  logic [3:0]       err;
  logic             err_any;
  logic [CNT_W-1:0] meas_period;

  int checks   = 0;
  int failures = 0;

  clk_div_checker #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOCK_COUNT  (LOCK_COUNT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div_in      (div_in),
    .start       (start),
    .meas_sel    (meas_sel),
    .locked      (locked),
    .err         (err),
    .err_any     (err_any),
    .meas_period (meas_period)
  );

  always #5 clk = ~clk;

  // Divider generators: stall stretches one period by a cycle, hold forces low,
  // skew1 gives channel 1 a 3-high/1-low waveform.
  int gen_cnt [NCH];
  bit stall   [NCH];
  bit hold    [NCH];
  bit skew1;

  // Reference model: timestamps of the last seen edge per channel.
  logic [3:0] hist [$];
  bit   m_armed  [NCH];
  bit   m_meas   [NCH];
  bit   m_locked [NCH];
  bit   m_err    [NCH];
  int   m_last   [NCH];
  int   m_good   [NCH];
  int   m_period [NCH];
  int   m_hi     [NCH];
  int   cyc;
  logic m_err_any;
  int   m_meas_period;
  logic [1:0] cur_sel;

  function automatic int expOf(input int k);
    return 2 ** (k + 1);
  endfunction

  function automatic logic [3:0] genDiv();
    logic [3:0] d;
    for (int k = 0; k < NCH; k++) begin
      d[k] = (gen_cnt[k] < expOf(k) / 2);
      if (k == 1 && skew1) d[k] = (gen_cnt[1] < 3);
      if (hold[k]) d[k] = 1'b0;
    end
    return d;
  endfunction

  task automatic advanceGen();
    for (int k = 0; k < NCH; k++) begin
      if (stall[k]) stall[k] = 0;
      else gen_cnt[k] = (gen_cnt[k] + 1) % expOf(k);
    end
  endtask

  task automatic modelJudge(input int k, input bit bad);
    if (bad) begin
      m_good[k] = 0;
      if (m_locked[k]) begin
        m_err[k]    = 1;
        m_locked[k] = 0;
      end
    end else if (!m_locked[k]) begin
      m_good[k]++;
      if (m_good[k] >= LOCK_COUNT) m_locked[k] = 1;
    end
  endtask

  task automatic modelClear(input bit arm);
    for (int k = 0; k < NCH; k++) begin
      m_armed[k] = arm; m_meas[k] = 0; m_locked[k] = 0; m_err[k] = 0;
      m_last[k] = 0; m_good[k] = 0; m_period[k] = 0; m_hi[k] = 0;
    end
  endtask

  task automatic modelEdge(input logic rst, input logic st, input logic [1:0] sel,
                           input logic [3:0] d);
    logic [3:0] rise;
    logic [3:0] lvl;
    logic       anyerr;
    int         el;
    bit         bad;
    hist.push_front(d);
    void'(hist.pop_back());
    if (rst) for (int i = 0; i < hist.size(); i++) hist[i] = 4'b0;
    rise = hist[SYNC_STAGES] & ~hist[SYNC_STAGES+1];
    lvl  = hist[SYNC_STAGES];
    cyc++;
    if (rst) begin
      modelClear(0);
      m_err_any     = 1'b0;
      m_meas_period = 0;
    end else begin
      anyerr = 1'b0;
      for (int k = 0; k < NCH; k++) anyerr |= m_err[k];
      m_err_any     = anyerr;
      m_meas_period = m_period[sel];
      if (st) modelClear(1);
      else begin
        for (int k = 0; k < NCH; k++) begin
          if (!m_armed[k]) continue;
          if (!m_meas[k]) begin
            if (rise[k]) begin m_meas[k] = 1; m_last[k] = cyc; m_hi[k] = 1; end
          end else begin
            el = cyc - m_last[k];
            if (rise[k]) begin
              bad = (el != expOf(k));
`ifdef CLK_DIV_CHECKER_DUTY_EN
              bad |= (m_hi[k] != expOf(k) / 2);
`endif
              m_period[k] = el;
              m_last[k]   = cyc;
              m_hi[k]     = 1;
              modelJudge(k, bad);
            end else if (el == 2 * expOf(k)) begin
              modelJudge(k, 1);
              m_meas[k] = 0;
            end else begin
              m_hi[k] += int'(lvl[k]);
            end
          end
        end
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] el;
    logic [3:0] ee;
    for (int k = 0; k < NCH; k++) begin el[k] = m_locked[k]; ee[k] = m_err[k]; end
    checkVal("locked", 32'(locked), 32'(el));
    checkVal("err", 32'(err), 32'(ee));
    checkVal("err_any", 32'(err_any), 32'(m_err_any));
    checkVal("meas_period", 32'(meas_period), 32'(m_meas_period));
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic [1:0] sel);
    reset    = rst;
    start    = st;
    meas_sel = sel;
    div_in   = genDiv();
    advanceGen();
    @(posedge clk);
    modelEdge(rst, st, sel, div_in);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, cur_sel);
  endtask

  initial begin
    bit found;
    for (int k = 0; k < NCH; k++) begin gen_cnt[k] = 0; stall[k] = 0; hold[k] = 0; end
    skew1 = 0;
    cyc = 0;
    cur_sel = 2'd0;
    repeat (SYNC_STAGES + 2) hist.push_back(4'b0);
    modelClear(0);
    reset = 1'b1; start = 1'b0; meas_sel = 2'd0; div_in = 4'b0;

    // Reset state, then free-running dividers without start must not lock.
    applyStimulus(1'b1, 1'b0, cur_sel);
    applyStimulus(1'b1, 1'b0, cur_sel);
    checkVal("reset_locked", 32'(locked), 0);
    checkVal("reset_meas_period", 32'(meas_period), 0);
    runCycles(50);
    checkVal("no_start_locked", 32'(locked), 0);

    // Ideal dividers lock all channels; channel 3 reads back 16.
    cur_sel = 2'd3;
    applyStimulus(1'b0, 1'b1, cur_sel);
    runCycles(150);
    checkVal("lock_all", 32'(locked), 32'hF);
    checkVal("lock_err", 32'(err), 0);
    checkVal("lock_period3", 32'(meas_period), 16);

    // One 9-cycle period on channel 2, then relock with the error kept.
    stall[2] = 1;
    runCycles(20);
    checkVal("glitch_err2", 32'(err[2]), 1);
    checkVal("glitch_locked2", 32'(locked[2]), 0);
    checkVal("glitch_err_any", 32'(err_any), 1);
    runCycles(50);
    checkVal("relock2", 32'(locked[2]), 1);
    checkVal("relock_err2", 32'(err[2]), 1);

    // Channel 3 stuck low: timeout error, then relock once toggling resumes.
    hold[3] = 1;
    runCycles(50);
    checkVal("hold_err3", 32'(err[3]), 1);
    checkVal("hold_locked3", 32'(locked[3]), 0);
    hold[3] = 0;
    runCycles(120);
    checkVal("resume_locked3", 32'(locked[3]), 1);

    // start coinciding with a channel 1 mismatch wins.
    stall[1] = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (hist[SYNC_STAGES-1][1] && !hist[SYNC_STAGES][1] && m_meas[1] &&
          (cyc + 1 - m_last[1]) != expOf(1)) begin
        applyStimulus(1'b0, 1'b1, cur_sel);
        found = 1;
      end else begin
        applyStimulus(1'b0, 1'b0, cur_sel);
      end
    end
    checkVal("start_mismatch_found", 32'(found), 1);
    checkVal("start_wins_err", 32'(err), 0);
    checkVal("start_wins_locked", 32'(locked), 0);

    // Reset together with start mid-measurement: everything clears, no relock.
    runCycles(30);
    applyStimulus(1'b1, 1'b1, cur_sel);
    checkVal("rst_start_locked", 32'(locked), 0);
    checkVal("rst_start_err_any", 32'(err_any), 0);
    checkVal("rst_start_period", 32'(meas_period), 0);
    runCycles(60);
    checkVal("rst_no_relock", 32'(locked), 0);

    // Channel 1 with correct period but 3-cycle high time after lock.
    cur_sel = 2'd1;
    applyStimulus(1'b0, 1'b1, cur_sel);
    runCycles(150);
    checkVal("duty_prelock", 32'(locked), 32'hF);
    skew1 = 1;
    runCycles(30);
`ifdef CLK_DIV_CHECKER_DUTY_EN
    checkVal("duty_err1", 32'(err[1]), 1);
    checkVal("duty_locked1", 32'(locked[1]), 0);
`else
    checkVal("duty_err1", 32'(err[1]), 0);
    checkVal("duty_locked1", 32'(locked[1]), 1);
`endif
    skew1 = 0;

    // Random stalls, holds, readback selects and occasional start pulses.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 6) stall[$urandom_range(0, NCH-1)] = 1;
      else if (r < 8) begin
        int c;
        c = $urandom_range(0, NCH-1);
        hold[c] = !hold[c];
      end
      cur_sel = 2'($urandom_range(0, 3));
      applyStimulus(1'b0, (r == 199), cur_sel);
    end
    for (int k = 0; k < NCH; k++) hold[k] = 0;
    runCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
